// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// rtl/nibble_serial_adder_ctrl_pkg.sv - shared state encodings and slice constants for the nibble-serial adder
package nibble_serial_adder_ctrl_pkg;

  localparam int ASQ_SLICE_W = 4;

  typedef enum logic [1:0] {
    ASQ_IDLE = 2'd0,
    ASQ_RUN  = 2'd1,
    ASQ_DONE = 2'd2
  } asq_state_e;

  // Slice index counter width; a single-slice build still needs one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// rtl/nibble_add_slice.sv - combinational 4-bit a+b+cin slice shared by the serial sequencer
module nibble_add_slice
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [ASQ_SLICE_W-1:0] a,
  input  logic [ASQ_SLICE_W-1:0] b,
  input  logic                   cin,
  output logic [ASQ_SLICE_W-1:0] s,
  output logic                   cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{ASQ_SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - nibble-serial add/sub sequencer, valid/ready both sides; ADDSEQ_SUBTRACT_EN adds op port
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4*NIBBLES-1:0]       a,
  input  logic [4*NIBBLES-1:0]       b,
`ifdef ADDSEQ_SUBTRACT_EN
  input  logic                       op,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*NIBBLES-1:0]       sum,
  output logic                       carry_out,
  output logic                       busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = idx_width(NIBBLES);

  asq_state_e state, state_d;

  logic [IW-1:0]          idx;
  logic                   carry;
  logic [W-1:0]           a_q;
  logic [W-1:0]           b_q;
  logic                   sub_q;
  logic                   last;

  logic [ASQ_SLICE_W-1:0] slice_a;
  logic [ASQ_SLICE_W-1:0] slice_b;
  logic [ASQ_SLICE_W-1:0] slice_s;
  logic                   slice_cout;
  logic [W-1:0]           sum_next;

  assign in_ready  = (state == ASQ_IDLE);
  assign out_valid = (state == ASQ_DONE);
  assign busy      = (state != ASQ_IDLE);
  assign last      = (idx == IW'(NIBBLES - 1));

`ifndef ADDSEQ_SUBTRACT_EN
  assign sub_q = 1'b0;
`endif

  // Route the current slice into the single shared adder and back into sum.
  always_comb begin
    slice_a  = '0;
    slice_b  = '0;
    sum_next = sum;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        slice_a = a_q[i*ASQ_SLICE_W +: ASQ_SLICE_W];
        slice_b = b_q[i*ASQ_SLICE_W +: ASQ_SLICE_W] ^ {ASQ_SLICE_W{sub_q}};
        sum_next[i*ASQ_SLICE_W +: ASQ_SLICE_W] = slice_s;
      end
    end
  end

  nibble_add_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state;
    case (state)
      ASQ_IDLE: if (in_valid)  state_d = ASQ_RUN;
      ASQ_RUN:  if (last)      state_d = ASQ_DONE;
      ASQ_DONE: if (out_ready) state_d = ASQ_IDLE;
      default:                 state_d = ASQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ASQ_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef ADDSEQ_SUBTRACT_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      state <= state_d;
      case (state)
        ASQ_IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            idx <= '0;
            sum <= '0;
`ifdef ADDSEQ_SUBTRACT_EN
            sub_q <= op;
            carry <= op;
`else
            carry <= 1'b0;
`endif
          end
        end
        ASQ_RUN: begin
          sum   <= sum_next;
          carry <= slice_cout;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) carry_out <= slice_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - vector table, corner sequences and random ops vs arithmetic model
module tb_nibble_serial_adder_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef ADDSEQ_SUBTRACT_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         co;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference result: W+1 bit true sum (A-B as A+~B+1 when subtracting).
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
    logic [W-1:0] yy;
    yy = o ? ~y : y;
    return {1'b0, x} + {1'b0, yy} + (W+1)'(o);
  endfunction

  // Low k nibbles of the result, the only part complete after k slice edges.
  function automatic logic [W-1:0] partial(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic o, input int k);
    logic [W-1:0] m;
    logic [W:0]   r;
    m = (k >= NIB) ? {W{1'b1}} : ((W'(1) << (4 * k)) - W'(1));
    r = model(x & m, (o ? ~y : y) & m, 1'b0) + (W+1)'(o);
    return r[W-1:0] & m;
  endfunction

  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic o,
                       input int hold, output logic [W-1:0] s, output logic c);
    logic [W:0]   exp;
    logic [W-1:0] held_s;
    logic         held_c;
    int           lat;
    exp = model(aa, bb, o);
    in_valid = 1'b1; a = aa; b = bb; op = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 1;
    for (int k = 1; k <= NIB; k++) begin
      @(posedge clk); #1;
      lat++;
      check($sformatf("partial_sum_k%0d", k), 32'(sum), 32'(partial(aa, bb, o, k)));
    end
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency_edges", 32'(lat), 32'(NIB + 1));
    check("sum", 32'(sum), 32'(exp[W-1:0]));
    check("carry_out", 32'(carry_out), 32'(exp[W]));
    held_s = sum; held_c = carry_out;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum_stable", 32'({held_c, held_s}), 32'({carry_out, sum}));
    end
    in_valid = 1'b0;
    s = sum; c = carry_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] s;
    logic         c;

    tbl[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{16'h1234, 16'h0FED, 16'h2221, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    tbl[4] = '{16'h0101, 16'h0202, 16'h0303, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
    tbl[6] = '{16'h0F0F, 16'h00F1, 16'h1000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry_out", 32'(carry_out), 32'd0);

    // Reset concurrent with a handshake must win.
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    check("rst_beats_accept", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].a, tbl[i].b, 1'b0, (i == 1) ? 3 : 0, s, c);
      check($sformatf("tbl%0d_sum", i), 32'(s), 32'(tbl[i].sum));
      check($sformatf("tbl%0d_co", i), 32'(c), 32'(tbl[i].co));
    end

    // Reset mid-operation after two RUN edges.
    in_valid = 1'b1; a = 16'h5555; b = 16'h5555; op = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    do_op(16'h0101, 16'h0202, 1'b0, 0, s, c);
    check("midrst_next_sum", 32'(s), 32'h0303);

`ifdef ADDSEQ_SUBTRACT_EN
    do_op(16'h0005, 16'h0007, 1'b1, 0, s, c);
    check("sub1_sum", 32'(s), 32'hFFFE);
    check("sub1_co", 32'(c), 32'd0);
    do_op(16'h0009, 16'h0003, 1'b1, 0, s, c);
    check("sub2_sum", 32'(s), 32'h0006);
    check("sub2_co", 32'(c), 32'd1);
`endif

    for (int r = 0; r < 30; r++) begin
`ifdef ADDSEQ_SUBTRACT_EN
      do_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2), s, c);
`else
      do_op(W'($urandom), W'($urandom), 1'b0, $urandom_range(0, 2), s, c);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
